// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 32-bit ALU among NREQ requesters; registered, ID-tagged result.
// Optional illegal-op flag resp_err is built only when ALU_SCHED_ERR_EN is defined.
module alu_rr_scheduler #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [6*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_rv1,
   input  logic [32*NREQ-1:0]   req_rv2,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [31:0]          resp_data
`ifdef ALU_SCHED_ERR_EN
   ,
   output logic                 resp_err
`endif
);

   localparam int unsigned OPW  = 6;
   localparam int unsigned XLEN = 32;
   localparam int unsigned SW   = IDW + 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  rr_ptr;
   logic            grant_valid;
   logic [IDW-1:0]  grant_idx;
   logic            can_accept;
   logic            transfer;
   logic [OPW-1:0]  op_arr  [NREQ];
   logic [XLEN-1:0] rv1_arr [NREQ];
   logic [XLEN-1:0] rv2_arr [NREQ];
   logic [OPW-1:0]  sel_op;
   logic [XLEN-1:0] sel_rv1, sel_rv2, alu_res;

   function automatic logic [XLEN-1:0] alu(input logic [OPW-1:0] op,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      case (op)
         6'h01, 6'h21, 6'h03: return a + b;
         6'h23:               return a - b;
         6'h09, 6'h29, 6'h0B: return {31'b0, ($signed(a) < $signed(b))};
         6'h0D, 6'h2D, 6'h0F: return {31'b0, (a < b)};
         6'h11, 6'h31, 6'h13: return a ^ b;
         6'h19, 6'h39, 6'h1B: return a | b;
         6'h1D, 6'h3D, 6'h1F: return a & b;
         6'h05, 6'h07:        return a << b[4:0];
         6'h15, 6'h17:        return a >> b[4:0];
         6'h35, 6'h37:        return XLEN'($signed(a) >>> b[4:0]);
         default:             return '0;
      endcase
   endfunction

`ifdef ALU_SCHED_ERR_EN
   function automatic logic op_illegal(input logic [OPW-1:0] op);
      case (op)
         6'h01, 6'h21, 6'h03, 6'h23,
         6'h09, 6'h29, 6'h0B, 6'h0D, 6'h2D, 6'h0F,
         6'h11, 6'h31, 6'h13, 6'h19, 6'h39, 6'h1B,
         6'h1D, 6'h3D, 6'h1F,
         6'h05, 6'h07, 6'h15, 6'h17, 6'h35, 6'h37: return 1'b0;
         default:                                   return 1'b1;
      endcase
   endfunction
`endif

   // Unpack the flat per-requester payload buses.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         op_arr[i]  = req_op[OPW*i +: OPW];
         rv1_arr[i] = req_rv1[XLEN*i +: XLEN];
         rv2_arr[i] = req_rv2[XLEN*i +: XLEN];
      end
   end

   // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         logic [SW-1:0] sum;
         sum = {1'b0, rr_ptr} + SW'(k);
         if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
         if (!grant_valid && req_valid[sum[IDW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = sum[IDW-1:0];
         end
      end
   end

   assign sel_op  = op_arr[grant_idx];
   assign sel_rv1 = rv1_arr[grant_idx];
   assign sel_rv2 = rv2_arr[grant_idx];
   assign alu_res = alu(sel_op, sel_rv1, sel_rv2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   // Output slot refills in the same cycle it drains.
   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      can_accept = !reset && ((state == EMPTY) || resp_ready);
      transfer   = can_accept && grant_valid;
      if (transfer) begin
         req_ready = NREQ'(1) << grant_idx;
         state_nxt = FULL;
      end else if (state == FULL && resp_ready) begin
         state_nxt = EMPTY;
      end
   end

   assign resp_valid = (state == FULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_data <= '0;
         resp_id   <= '0;
         rr_ptr    <= '0;
      end else if (transfer) begin
         resp_data <= alu_res;
         resp_id   <= grant_idx;
         rr_ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
   end

`ifdef ALU_SCHED_ERR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         resp_err <= 1'b0;
      else if (transfer) resp_err <= op_illegal(sel_op);
   end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler (NREQ=4); checks resp_err when ALU_SCHED_ERR_EN is defined.
module tb_alu_rr_scheduler;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [6*NREQ-1:0]   req_op;
   logic [32*NREQ-1:0]  req_rv1;
   logic [32*NREQ-1:0]  req_rv2;
   logic                resp_valid;
   logic                resp_ready;
   logic [IDW-1:0]      resp_id;
   logic [31:0]         resp_data;
`ifdef ALU_SCHED_ERR_EN
   logic                resp_err;
`endif

   int checks = 0;
   int errors = 0;

   alu_rr_scheduler #(.NREQ(NREQ)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rv1    (req_rv1),
      .req_rv2    (req_rv2),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data)
`ifdef ALU_SCHED_ERR_EN
      ,
      .resp_err   (resp_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[6*i +: 6]   = op;
      req_rv1[32*i +: 32] = a;
      req_rv2[32*i +: 32] = b;
   endtask

   // Arithmetic vectors: op, rv1, rv2, expected result, expected illegal flag.
   logic [5:0]  v_op  [9] = '{6'h35, 6'h09, 6'h0D, 6'h23, 6'h3F, 6'h15, 6'h1D, 6'h11, 6'h39};
   logic [31:0] v_a   [9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1,
                              32'h8000_0000, 32'h0000_F0F0, 32'h0000_00FF, 32'h0000_00F0};
   logic [31:0] v_b   [9] = '{32'h24, 32'h1, 32'h1, 32'h1, 32'h1, 32'h4, 32'h0000_FF00, 32'h0F, 32'h0F};
   logic [31:0] v_exp [9] = '{32'hF800_0000, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0,
                              32'h0800_0000, 32'h0000_F000, 32'h0000_00F0, 32'h0000_00FF};
   logic        v_err [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      reset      = 1'b1;
      req_valid  = '1;
      resp_ready = 1'b1;
      req_op     = '0;
      req_rv1    = '0;
      req_rv2    = '0;
      for (int i = 0; i < NREQ; i++) set_req(i, 6'h03, 32'(16 * i), 32'h1);
      #3;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_resp_id", 32'(resp_id), 32'h0);
`ifdef ALU_SCHED_ERR_EN
      check("rst_resp_err", 32'(resp_err), 32'h0);
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // All requesters valid: strict rotation 0,1,2,3,0 one per cycle.
      for (int k = 0; k < 5; k++) begin
         #1 check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         step();
         check($sformatf("rr_valid_%0d", k), 32'(resp_valid), 32'h1);
         check($sformatf("rr_id_%0d", k), 32'(resp_id), 32'(k % 4));
         check($sformatf("rr_data_%0d", k), resp_data, 32'(16 * (k % 4) + 1));
      end

      // Only requester 1 valid: served every cycle although rr_ptr moves.
      req_valid = 4'b0010;
      set_req(1, 6'h03, 32'd7, 32'd5);
      for (int k = 0; k < 2; k++) begin
         #1 check($sformatf("single_ready_%0d", k), 32'(req_ready), 32'h2);
         step();
         check($sformatf("single_valid_%0d", k), 32'(resp_valid), 32'h1);
         check($sformatf("single_id_%0d", k), 32'(resp_id), 32'h1);
         check($sformatf("single_data_%0d", k), resp_data, 32'd12);
      end

      // Backpressure: FULL and consumer stalled for 3 cycles.
      resp_ready = 1'b0;
      set_req(1, 6'h23, 32'h0, 32'h1);
      for (int k = 0; k < 3; k++) begin
         #1 check($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'h0);
         step();
         check($sformatf("bp_valid_%0d", k), 32'(resp_valid), 32'h1);
         check($sformatf("bp_data_%0d", k), resp_data, 32'd12);
         check($sformatf("bp_id_%0d", k), 32'(resp_id), 32'h1);
      end
      resp_ready = 1'b1;
      #1 check("bp_release_ready", 32'(req_ready), 32'h2);
      step();
      check("bp_refill_valid", 32'(resp_valid), 32'h1);
      check("bp_refill_data", resp_data, 32'hFFFF_FFFF);

      // ALU vectors through requester 2.
      req_valid = 4'b0100;
      for (int k = 0; k < 9; k++) begin
         set_req(2, v_op[k], v_a[k], v_b[k]);
         #1 check($sformatf("alu_ready_%0d", k), 32'(req_ready), 32'h4);
         step();
         check($sformatf("alu_id_%0d", k), 32'(resp_id), 32'h2);
         check($sformatf("alu_data_op%h", v_op[k]), resp_data, v_exp[k]);
`ifdef ALU_SCHED_ERR_EN
         check($sformatf("alu_err_op%h", v_op[k]), 32'(resp_err), 32'(v_err[k]));
`endif
      end

      // Drain with no new request: slot empties, data and id held.
      req_valid = '0;
      step();
      check("drain_valid", 32'(resp_valid), 32'h0);
      check("drain_data", resp_data, 32'h0000_00FF);
      check("drain_id", 32'(resp_id), 32'h2);

      // Reset while FULL and stalled discards the held result.
      resp_ready = 1'b0;
      req_valid  = 4'b1000;
      set_req(3, 6'h01, 32'h1, 32'h1);
      step();
      check("pre_rst_valid", 32'(resp_valid), 32'h1);
      check("pre_rst_data", resp_data, 32'h2);
      check("pre_rst_id", 32'(resp_id), 32'h3);
      req_valid = '1;
      set_req(0, 6'h01, 32'd5, 32'd6);
      #1 check("pre_rst_ready", 32'(req_ready), 32'h0);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(resp_valid), 32'h0);
      check("mid_rst_data", resp_data, 32'h0);
      check("mid_rst_id", 32'(resp_id), 32'h0);
      check("mid_rst_ready", 32'(req_ready), 32'h0);
      #1 reset = 1'b0;
      #1 check("post_rst_ready", 32'(req_ready), 32'h1);
      step();
      check("post_rst_valid", 32'(resp_valid), 32'h1);
      check("post_rst_id", 32'(resp_id), 32'h0);
      check("post_rst_data", resp_data, 32'd11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
